// File: rtl/buffer_pkg.sv
// Shared constants and the entry record for the pending-request buffer.
package buffer_pkg;

   localparam int NUM_CLUSTERS_PADRAO  = 5;
   localparam int TAM_ENDERECO_PADRAO  = 64;
   localparam int TAM_HASH_DOIS_PADRAO = 8;
   localparam int TAM_BUFFER_PADRAO    = 32;
   localparam int LIMIAR_PADRAO        = TAM_BUFFER_PADRAO - 4;
   localparam int AUTO_RETIRAR_PADRAO  = 1;

   // One pending request at the default widths: which clusters still owe
   // an answer, the address it refers to and its secondary hash.
   typedef struct packed {
      logic [NUM_CLUSTERS_PADRAO-1:0]  bitmap;
      logic [TAM_ENDERECO_PADRAO-1:0]  endereco;
      logic [TAM_HASH_DOIS_PADRAO-1:0] hash;
   } entrada_t;

endpackage

// File: rtl/buffer_memoria.sv
// Slot array of the pending buffer: a write port at the tail, a read port
// at the head and a bitmap-only rewrite port at the head.
module buffer_memoria
   import buffer_pkg::*;
#(
   parameter int NUM_CLUSTERS  = NUM_CLUSTERS_PADRAO,
   parameter int TAM_ENDERECO  = TAM_ENDERECO_PADRAO,
   parameter int TAM_HASH_DOIS = TAM_HASH_DOIS_PADRAO,
   parameter int TAM_BUFFER    = TAM_BUFFER_PADRAO,
   localparam int PW           = $clog2(TAM_BUFFER)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     escreverEn_i,
   input  logic [PW-1:0]            escreverPtr_i,
   input  logic [NUM_CLUSTERS-1:0]  bitmapEscrita_i,
   input  logic [TAM_ENDERECO-1:0]  enderecoEscrita_i,
   input  logic [TAM_HASH_DOIS-1:0] hashEscrita_i,
   input  logic                     atualizarEn_i,
   input  logic [PW-1:0]            atualizarPtr_i,
   input  logic [NUM_CLUSTERS-1:0]  bitmapAtualizado_i,
   input  logic [PW-1:0]            lerPtr_i,
   output logic [NUM_CLUSTERS-1:0]  bitmapLido_o,
   output logic [TAM_ENDERECO-1:0]  enderecoLido_o,
   output logic [TAM_HASH_DOIS-1:0] hashLido_o
);

   logic [NUM_CLUSTERS-1:0]  bitmapMem_q   [TAM_BUFFER];
   logic [TAM_ENDERECO-1:0]  enderecoMem_q [TAM_BUFFER];
   logic [TAM_HASH_DOIS-1:0] hashMem_q     [TAM_BUFFER];

   // Slot storage: cleared on reset; the tail write and the head bitmap
   // rewrite never target the same slot because the controller only updates
   // a non-empty buffer and only writes a non-full one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAM_BUFFER; i++) begin
            bitmapMem_q[i]   <= '0;
            enderecoMem_q[i] <= '0;
            hashMem_q[i]     <= '0;
         end
      end else begin
         if (escreverEn_i) begin
            bitmapMem_q[escreverPtr_i]   <= bitmapEscrita_i;
            enderecoMem_q[escreverPtr_i] <= enderecoEscrita_i;
            hashMem_q[escreverPtr_i]     <= hashEscrita_i;
         end
         if (atualizarEn_i) begin
            bitmapMem_q[atualizarPtr_i] <= bitmapAtualizado_i;
         end
      end
   end

   // Head read is purely combinational so a new head shows up the cycle
   // after the pointer moves.
   always_comb begin
      bitmapLido_o   = bitmapMem_q[lerPtr_i];
      enderecoLido_o = enderecoMem_q[lerPtr_i];
      hashLido_o     = hashMem_q[lerPtr_i];
   end

endmodule

// File: rtl/buffer_pendentes.sv
// Circular buffer of pending requests: head/tail pointers, occupancy count,
// retire/update/flush priority and the sticky empty-access error flag.
module buffer_pendentes
   import buffer_pkg::*;
#(
   parameter int NUM_CLUSTERS       = NUM_CLUSTERS_PADRAO,
   parameter int TAM_ENDERECO       = TAM_ENDERECO_PADRAO,
   parameter int TAM_HASH_DOIS      = TAM_HASH_DOIS_PADRAO,
   parameter int TAM_BUFFER         = TAM_BUFFER_PADRAO,
   parameter int LIMIAR_QUASE_CHEIO = TAM_BUFFER - 4,
   parameter int AUTO_RETIRAR       = AUTO_RETIRAR_PADRAO,
   localparam int CW                = $clog2(TAM_BUFFER + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     entrada_valida,
   output logic                     entrada_pronta,
   input  logic [NUM_CLUSTERS-1:0]  bitmap_novo,
   input  logic [TAM_ENDERECO-1:0]  endereco_novo,
   input  logic [TAM_HASH_DOIS-1:0] hash_nova,
   input  logic                     atualizar,
   input  logic [NUM_CLUSTERS-1:0]  bitmap_atualizado,
   input  logic                     retirar,
   input  logic                     esvaziar,
   output logic [NUM_CLUSTERS-1:0]  bitmap_atual,
   output logic [TAM_ENDERECO-1:0]  endereco_atual,
   output logic [TAM_HASH_DOIS-1:0] hash_atual,
   output logic                     saida_valida,
   output logic [CW-1:0]            ocupacao,
   output logic                     quase_cheio,
   output logic                     bloquear,
   output logic                     erro_sem_entrada
);

   localparam int PW = $clog2(TAM_BUFFER);
   localparam logic [CW-1:0] CAPACIDADE = CW'(TAM_BUFFER);
   localparam logic [CW-1:0] LIMIAR     = CW'(LIMIAR_QUASE_CHEIO);
   localparam logic [CW-1:0] UM         = CW'(1);
   localparam logic [PW-1:0] PASSO      = PW'(1);

   logic [PW-1:0] cabeca_q, cabeca_d;
   logic [PW-1:0] cauda_q, cauda_d;
   logic [CW-1:0] ocupacao_q, ocupacao_d;
   logic          erro_q, erro_d;

   logic pedidoRetirada;
   logic pushFeito;
   logic retiradaFeita;
   logic atualizacaoFeita;
   logic acessoVazio;

   // Status flags come from the registered count only, so a retire in the
   // same cycle never opens room for a push into a full buffer.
   always_comb begin
      entrada_pronta   = (ocupacao_q < CAPACIDADE);
      bloquear         = ~entrada_pronta;
      saida_valida     = (ocupacao_q != '0);
      quase_cheio      = (ocupacao_q >= LIMIAR);
      ocupacao         = ocupacao_q;
      erro_sem_entrada = erro_q;
   end

   // Command decode and next state: flush beats everything, a retire (explicit
   // or via an all-zero bitmap) beats an update, and commands on an empty
   // buffer are dropped but remembered in the sticky error flag.
   always_comb begin
      pedidoRetirada   = retirar ||
                         ((AUTO_RETIRAR != 0) && atualizar && (bitmap_atualizado == '0));
      pushFeito        = entrada_valida && entrada_pronta && !esvaziar;
      retiradaFeita    = saida_valida && pedidoRetirada && !esvaziar;
      atualizacaoFeita = saida_valida && atualizar && !pedidoRetirada && !esvaziar;
      acessoVazio      = !saida_valida && (atualizar || retirar) && !esvaziar;

      cabeca_d   = cabeca_q;
      cauda_d    = cauda_q;
      ocupacao_d = ocupacao_q;
      erro_d     = erro_q;

      if (esvaziar) begin
         cabeca_d   = '0;
         cauda_d    = '0;
         ocupacao_d = '0;
         erro_d     = 1'b0;
      end else begin
         if (pushFeito) begin
            cauda_d = cauda_q + PASSO;
         end
         if (retiradaFeita) begin
            cabeca_d = cabeca_q + PASSO;
         end
         if (pushFeito && !retiradaFeita) begin
            ocupacao_d = ocupacao_q + UM;
         end else if (retiradaFeita && !pushFeito) begin
            ocupacao_d = ocupacao_q - UM;
         end
         if (acessoVazio) begin
            erro_d = 1'b1;
         end
      end
   end

   // Pointer, count and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cabeca_q   <= '0;
         cauda_q    <= '0;
         ocupacao_q <= '0;
         erro_q     <= 1'b0;
      end else begin
         cabeca_q   <= cabeca_d;
         cauda_q    <= cauda_d;
         ocupacao_q <= ocupacao_d;
         erro_q     <= erro_d;
      end
   end

   buffer_memoria #(
      .NUM_CLUSTERS  (NUM_CLUSTERS),
      .TAM_ENDERECO  (TAM_ENDERECO),
      .TAM_HASH_DOIS (TAM_HASH_DOIS),
      .TAM_BUFFER    (TAM_BUFFER)
   ) uMemoria (
      .clk                (clk),
      .rst_n              (rst_n),
      .escreverEn_i       (pushFeito),
      .escreverPtr_i      (cauda_q),
      .bitmapEscrita_i    (bitmap_novo),
      .enderecoEscrita_i  (endereco_novo),
      .hashEscrita_i      (hash_nova),
      .atualizarEn_i      (atualizacaoFeita),
      .atualizarPtr_i     (cabeca_q),
      .bitmapAtualizado_i (bitmap_atualizado),
      .lerPtr_i           (cabeca_q),
      .bitmapLido_o       (bitmap_atual),
      .enderecoLido_o     (endereco_atual),
      .hashLido_o         (hash_atual)
   );

endmodule

// File: tb/tb_buffer_pendentes.sv
// Directed self-checking bench for buffer_pendentes with a depth-4 buffer.
module tb_buffer_pendentes;

   localparam int NC  = 5;
   localparam int TE  = 64;
   localparam int TH  = 8;
   localparam int TB  = 4;
   localparam int LIM = 3;
   localparam int CW  = $clog2(TB + 1);

   logic          clk;
   logic          rst_n;
   logic          entrada_valida;
   logic          entrada_pronta;
   logic [NC-1:0] bitmap_novo;
   logic [TE-1:0] endereco_novo;
   logic [TH-1:0] hash_nova;
   logic          atualizar;
   logic [NC-1:0] bitmap_atualizado;
   logic          retirar;
   logic          esvaziar;
   logic [NC-1:0] bitmap_atual;
   logic [TE-1:0] endereco_atual;
   logic [TH-1:0] hash_atual;
   logic          saida_valida;
   logic [CW-1:0] ocupacao;
   logic          quase_cheio;
   logic          bloquear;
   logic          erro_sem_entrada;

   int checks = 0;
   int errors = 0;

   buffer_pendentes #(
      .NUM_CLUSTERS       (NC),
      .TAM_ENDERECO       (TE),
      .TAM_HASH_DOIS      (TH),
      .TAM_BUFFER         (TB),
      .LIMIAR_QUASE_CHEIO (LIM),
      .AUTO_RETIRAR       (1)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .entrada_valida    (entrada_valida),
      .entrada_pronta    (entrada_pronta),
      .bitmap_novo       (bitmap_novo),
      .endereco_novo     (endereco_novo),
      .hash_nova         (hash_nova),
      .atualizar         (atualizar),
      .bitmap_atualizado (bitmap_atualizado),
      .retirar           (retirar),
      .esvaziar          (esvaziar),
      .bitmap_atual      (bitmap_atual),
      .endereco_atual    (endereco_atual),
      .hash_atual        (hash_atual),
      .saida_valida      (saida_valida),
      .ocupacao          (ocupacao),
      .quase_cheio       (quase_cheio),
      .bloquear          (bloquear),
      .erro_sem_entrada  (erro_sem_entrada)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs, waits for the edge, samples 1 ns later and
   // returns all inputs to idle.
   task automatic applyStimulus(input logic v, input logic [TE-1:0] addr, input logic [NC-1:0] bm,
                                input logic [TH-1:0] h, input logic upd, input logic [NC-1:0] bmUpd,
                                input logic ret, input logic flush);
      entrada_valida    = v;
      endereco_novo     = addr;
      bitmap_novo       = bm;
      hash_nova         = h;
      atualizar         = upd;
      bitmap_atualizado = bmUpd;
      retirar           = ret;
      esvaziar          = flush;
      @(posedge clk);
      #1;
      entrada_valida    = 1'b0;
      endereco_novo     = '0;
      bitmap_novo       = '0;
      hash_nova         = '0;
      atualizar         = 1'b0;
      bitmap_atualizado = '0;
      retirar           = 1'b0;
      esvaziar          = 1'b0;
   endtask

   task automatic pushOnly(input logic [TE-1:0] addr, input logic [NC-1:0] bm, input logic [TH-1:0] h);
      applyStimulus(1'b1, addr, bm, h, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic retireOnly();
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      entrada_valida = 1'b0; endereco_novo = '0; bitmap_novo = '0; hash_nova = '0;
      atualizar = 1'b0; bitmap_atualizado = '0; retirar = 1'b0; esvaziar = 1'b0;
      #12;
      checkOutput("rst_saida_valida", saida_valida, 0);
      checkOutput("rst_entrada_pronta", entrada_pronta, 1);
      checkOutput("rst_bloquear", bloquear, 0);
      checkOutput("rst_quase_cheio", quase_cheio, 0);
      checkOutput("rst_ocupacao", ocupacao, 0);
      checkOutput("rst_endereco", endereco_atual, 0);
      checkOutput("rst_bitmap", bitmap_atual, 0);
      checkOutput("rst_erro", erro_sem_entrada, 0);
      rst_n = 1'b1;

      // Basic FIFO order and one-cycle visibility
      pushOnly(64'h10, 5'b00011, 8'hA1);
      checkOutput("a_ocupacao", ocupacao, 1);
      checkOutput("a_endereco", endereco_atual, 64'h10);
      checkOutput("a_bitmap", bitmap_atual, 5'b00011);
      checkOutput("a_hash", hash_atual, 8'hA1);
      pushOnly(64'h20, 5'b00101, 8'hB2);
      checkOutput("ab_ocupacao", ocupacao, 2);
      checkOutput("ab_endereco", endereco_atual, 64'h10);
      retireOnly();
      checkOutput("pop_endereco", endereco_atual, 64'h20);
      checkOutput("pop_ocupacao", ocupacao, 1);
      retireOnly();
      checkOutput("empty_valida", saida_valida, 0);

      // Fill to capacity
      pushOnly(64'h30, 5'b11111, 8'h30);
      pushOnly(64'h31, 5'b11111, 8'h31);
      pushOnly(64'h32, 5'b11111, 8'h32);
      checkOutput("three_quase", quase_cheio, 1);
      checkOutput("three_pronta", entrada_pronta, 1);
      pushOnly(64'h33, 5'b11111, 8'h33);
      checkOutput("full_ocupacao", ocupacao, 4);
      checkOutput("full_pronta", entrada_pronta, 0);
      checkOutput("full_bloquear", bloquear, 1);
      pushOnly(64'h99, 5'b11111, 8'h99);
      checkOutput("overflow_ocupacao", ocupacao, 4);
      checkOutput("overflow_head", endereco_atual, 64'h30);
      applyStimulus(1'b1, 64'h77, 5'b11111, 8'h77, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("full_pushret_ocup", ocupacao, 3);
      checkOutput("full_pushret_head", endereco_atual, 64'h31);
      pushOnly(64'h78, 5'b11111, 8'h78);
      checkOutput("refill_ocupacao", ocupacao, 4);
      retireOnly();
      checkOutput("drain1_head", endereco_atual, 64'h32);
      retireOnly();
      checkOutput("drain2_head", endereco_atual, 64'h33);
      retireOnly();
      checkOutput("drain3_head", endereco_atual, 64'h78);
      retireOnly();
      checkOutput("drain4_ocupacao", ocupacao, 0);

      // Head bitmap update, auto retire on zero, retire beats update
      pushOnly(64'h40, 5'b10110, 8'h40);
      pushOnly(64'h41, 5'b01000, 8'h41);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'b00001, 1'b0, 1'b0);
      checkOutput("upd_bitmap", bitmap_atual, 5'b00001);
      checkOutput("upd_ocupacao", ocupacao, 2);
      checkOutput("upd_endereco", endereco_atual, 64'h40);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'b00000, 1'b0, 1'b0);
      checkOutput("auto_ocupacao", ocupacao, 1);
      checkOutput("auto_endereco", endereco_atual, 64'h41);
      checkOutput("auto_bitmap", bitmap_atual, 5'b01000);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'b00111, 1'b1, 1'b0);
      checkOutput("retwins_ocupacao", ocupacao, 0);
      checkOutput("retwins_erro", erro_sem_entrada, 0);

      // Empty access error, stickiness and flush
      retireOnly();
      checkOutput("err_set", erro_sem_entrada, 1);
      checkOutput("err_ocupacao", ocupacao, 0);
      pushOnly(64'h50, 5'b00010, 8'h50);
      checkOutput("err_sticky", erro_sem_entrada, 1);
      checkOutput("err_push_ocup", ocupacao, 1);
      applyStimulus(1'b1, 64'h51, 5'b00010, 8'h51, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("flush_erro", erro_sem_entrada, 0);
      checkOutput("flush_ocupacao", ocupacao, 0);
      checkOutput("flush_valida", saida_valida, 0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'b00100, 1'b0, 1'b0);
      checkOutput("upd_empty_erro", erro_sem_entrada, 1);

      // Ten push+retire pairs around the ring
      pushOnly(64'h60, 5'b00001, 8'h60);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 64'h60 + 64'(i), 5'b00001, 8'(8'h60 + i), 1'b0, '0, 1'b1, 1'b0);
         checkOutput("wrap_head", endereco_atual, 64'h60 + 64'(i));
         checkOutput("wrap_ocupacao", ocupacao, 1);
      end
      retireOnly();
      checkOutput("wrap_empty", ocupacao, 0);

      // Asynchronous reset in the middle of a cycle with entries held
      pushOnly(64'h80, 5'b00011, 8'h80);
      pushOnly(64'h81, 5'b00011, 8'h81);
      pushOnly(64'h82, 5'b00011, 8'h82);
      checkOutput("pre_rst_ocupacao", ocupacao, 3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_ocupacao", ocupacao, 0);
      checkOutput("mid_rst_valida", saida_valida, 0);
      checkOutput("mid_rst_endereco", endereco_atual, 0);
      checkOutput("mid_rst_pronta", entrada_pronta, 1);
      checkOutput("mid_rst_erro", erro_sem_entrada, 0);
      #2;
      rst_n = 1'b1;
      pushOnly(64'h90, 5'b00110, 8'h90);
      checkOutput("post_rst_head", endereco_atual, 64'h90);
      checkOutput("post_rst_ocupacao", ocupacao, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/buffer_pendentes.md
BUFFER_PENDENTES -- requirements
Module: buffer_pendentes

Interface
REQ-001 Parameter NUM_CLUSTERS, default 5, SHALL set the cluster bitmap width.
REQ-002 Parameter TAM_ENDERECO, default 64, SHALL set the address width.
REQ-003 Parameter TAM_HASH_DOIS, default 8, SHALL set the secondary hash width.
REQ-004 Parameter TAM_BUFFER, default 32 (power of two, >=2), SHALL set the entry depth.
REQ-005 Parameter LIMIAR_QUASE_CHEIO, default TAM_BUFFER-4, SHALL set the almost-full threshold.
REQ-006 Parameter AUTO_RETIRAR, default 1, SHALL enable retire-on-zero-bitmap.
REQ-007 Ports: one clock; reset is asynchronous and active-low: clk input 1 (clock); rst_n input 1 (reset).
REQ-008 entrada_valida input 1: push request; entrada_pronta output 1: push accepted this cycle.
REQ-009 bitmap_novo input NUM_CLUSTERS; endereco_novo input TAM_ENDERECO; hash_nova input TAM_HASH_DOIS: push payload.
REQ-010 atualizar input 1 with bitmap_atualizado input NUM_CLUSTERS: rewrite head bitmap.
REQ-011 retirar input 1: pop head; esvaziar input 1: synchronous flush.
REQ-012 bitmap_atual, endereco_atual, hash_atual outputs (payload widths): head entry; saida_valida output 1: head exists.
REQ-013 ocupacao output $clog2(TAM_BUFFER+1); quase_cheio output 1; bloquear output 1; erro_sem_entrada output 1 (sticky).

Function
REQ-014 Storage SHALL be a circular array with registered head/tail pointers and occupancy counter; no shifting of entries.
REQ-015 entrada_pronta SHALL equal (ocupacao < TAM_BUFFER) from the registered count only; bloquear SHALL equal ~entrada_pronta.
REQ-016 Push (entrada_valida && entrada_pronta) SHALL write payload at tail and advance tail mod TAM_BUFFER at the clk rising edge.
REQ-017 Head outputs SHALL be combinational reads of the head slot; saida_valida SHALL equal (ocupacao != 0); push-to-output latency 1 cycle.
REQ-018 atualizar with saida_valida SHALL write bitmap_atualizado into the head slot.
REQ-019 With AUTO_RETIRAR=1, atualizar with bitmap_atualizado==0 SHALL retire the head at the same edge.
REQ-020 retirar with saida_valida SHALL advance head mod TAM_BUFFER.
REQ-021 Simultaneous retirar and atualizar: retire SHALL win, update discarded.
REQ-022 Simultaneous push and retire: ocupacao SHALL be unchanged; push while full SHALL NOT occur even if head retires that cycle.
REQ-023 atualizar or retirar while empty SHALL be ignored and SHALL set erro_sem_entrada.
REQ-024 esvaziar SHALL have highest priority: head, tail, ocupacao, erro_sem_entrada to 0; concurrent push/update/retire dropped.
REQ-025 quase_cheio SHALL equal (ocupacao >= LIMIAR_QUASE_CHEIO).
REQ-026 Pointer wrap SHALL be silent; ocupacao SHALL never exceed TAM_BUFFER nor underflow.

Reset
REQ-027 rst_n low SHALL immediately clear head, tail, ocupacao, erro_sem_entrada and all storage slots to 0.
REQ-028 Reset outputs: saida_valida 0, entrada_pronta 1, bloquear 0, quase_cheio 0 (LIMIAR>0), payload outputs 0, ocupacao 0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; first push after release SHALL land in slot 0.

Structure
REQ-030 Package buffer_pkg SHALL hold default parameter constants and the entry struct type (bitmap, endereco, hash).
REQ-031 One sub-module buffer_memoria SHALL hold the slot array: one write port (tail), one read port (head), one head bitmap-update port.
REQ-032 Pointer, counter and priority logic SHALL reside in buffer_pendentes.

Verification (TAM_BUFFER=4, LIMIAR=3, NUM_CLUSTERS=5)
REQ-033 Push A(end=0x10,bm=5'b00011),B(0x20) -> next cycle endereco_atual=0x10, ocupacao=2; retirar -> endereco_atual=0x20.
REQ-034 Push 4 entries -> entrada_pronta=0, bloquear=1, quase_cheio=1 at ocupacao 3; fifth push ignored; push+retire when full -> ocupacao 3 then 4.
REQ-035 atualizar bm=5'b00001 -> bitmap_atual=00001, ocupacao kept; atualizar bm=0 -> head retires, ocupacao-1.
REQ-036 retirar while empty -> erro_sem_entrada=1 sticky; esvaziar -> erro 0, ocupacao 0, saida_valida 0.
REQ-037 10 push/retire pairs -> pointers wrap, FIFO order preserved, ocupacao stays 1.
REQ-038 rst_n low mid-cycle with 3 entries -> outputs immediately at reset values; next push visible at slot 0.
